// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: state encodings and
// the bit-counter width helper.
package serial_add_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A one-bit counter is still needed when WIDTH is 1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_cell.sv
// Combinational 1-bit full adder; the controller time-multiplexes a single instance.
module serial_add_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: valid/ready operand intake, LSB-first ripple over
// WIDTH cycles through one shared adder cell, registered result with valid/ready.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter bit          CARRY_IN_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             cell_s, cell_c;

    serial_add_cell u_cell (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (cell_s),
        .c_o (cell_c)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (clr) begin
            // Abort keeps the last completed result visible on sum/cout.
            state_d = ST_IDLE;
            cnt_d   = '0;
            carry_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_d  = a;
                        b_sh_d  = b;
                        acc_d   = '0;
                        carry_d = cin & CARRY_IN_EN;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_d           = a_sh_q >> 1;
                    b_sh_d           = b_sh_q >> 1;
                    acc_d            = acc_q >> 1;
                    acc_d[WIDTH-1]   = cell_s;
                    carry_d          = cell_c;
                    cnt_d            = cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        sum_d   = acc_d;
                        cout_d  = cell_c;
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench: full-adder and half-adder configurations driven in lockstep,
// vector table plus scoreboard-checked handshakes, abort, async reset and streaming.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr, in_valid, out_ready, cin;
    logic [W-1:0] a, b;
    logic         in_ready, out_valid, busy, cout;
    logic [W-1:0] sum;
    logic         in_ready_h, out_valid_h, busy_h, cout_h;
    logic [W-1:0] sum_h;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W), .CARRY_IN_EN(1'b1)) u_dut_fa (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_add_ctrl #(.WIDTH(W), .CARRY_IN_EN(1'b0)) u_dut_ha (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_h),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid_h), .out_ready(out_ready),
        .sum(sum_h), .cout(cout_h), .busy(busy_h)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_pop = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] s1;
        logic         c1;
        logic [W-1:0] s0;
        logic         c0;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s1;
        logic         c1;
        logic [W-1:0] s0;
        logic         c0;
    } vec_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: sampled on the falling edge, so it sees exactly what the next rising edge does.
    logic [W:0] t1, t0;
    exp_t       e_push, e_pop;
    always @(negedge clk) begin
        if (rst_n) begin
            if (clr) begin
                if (busy && sb.size() > 0) sb.delete(sb.size() - 1);
            end else begin
                if (in_valid && in_ready) begin
                    t1 = 9'(a) + 9'(b) + 9'(cin);
                    t0 = 9'(a) + 9'(b);
                    e_push.s1 = t1[W-1:0];
                    e_push.c1 = t1[W];
                    e_push.s0 = t0[W-1:0];
                    e_push.c0 = t0[W];
                    sb.push_back(e_push);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_result", 1, 0);
                    end else begin
                        e_pop = sb.pop_front();
                        chk("sb_sum_fa", 32'(sum), 32'(e_pop.s1));
                        chk("sb_cout_fa", 32'(cout), 32'(e_pop.c1));
                        chk("sb_sum_ha", 32'(sum_h), 32'(e_pop.s0));
                        chk("sb_cout_ha", 32'(cout_h), 32'(e_pop.c0));
                        chk("sb_valid_lockstep", 32'(out_valid_h), 1);
                    end
                    n_pop++;
                end
            end
        end
    end

    always @(negedge rst_n) sb.delete();

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
        a        = ta;
        b        = tb_v;
        cin      = tc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    vec_t         vecs[6];
    int           lat;
    logic [W-1:0] hold_s;
    logic         hold_c;
    logic         ov_seen, fire;
    int           acc_n, last_cyc, pops_before;

    initial begin
        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 8'h7F, 1'b0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 8'h00, 1'b1};
        vecs[4] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b0};
        vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 8'h46, 1'b0};

        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            chk("vec_ready_before", 32'(in_ready), 1);
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done(lat);
            chk("vec_latency", 32'(lat), W);
            chk("vec_sum_fa", 32'(sum), 32'(vecs[i].s1));
            chk("vec_cout_fa", 32'(cout), 32'(vecs[i].c1));
            chk("vec_sum_ha", 32'(sum_h), 32'(vecs[i].s0));
            chk("vec_cout_ha", 32'(cout_h), 32'(vecs[i].c0));
            chk("vec_busy_done", 32'(busy), 1);
            @(posedge clk);
            #1;
            chk("vec_valid_drop", 32'(out_valid), 0);
            chk("vec_ready_back", 32'(in_ready), 1);
        end

        // Backpressure in DONE with new operands offered.
        out_ready = 1'b0;
        start_op(8'h0F, 8'h01, 1'b0);
        wait_done(lat);
        chk("bp_latency", 32'(lat), W);
        chk("bp_sum", 32'(sum), 32'h10);
        hold_s   = sum;
        hold_c   = cout;
        a        = 8'hAA;
        b        = 8'h55;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_valid_held", 32'(out_valid), 1);
            chk("bp_sum_held", 32'(sum), 32'(hold_s));
            chk("bp_cout_held", 32'(cout), 32'(hold_c));
            chk("bp_not_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_ready", 32'(in_ready), 1);
        chk("bp_release_valid", 32'(out_valid), 0);
        chk("bp_release_busy", 32'(busy), 0);

        // Abort after three RUN edges.
        start_op(8'h77, 8'h11, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("abort_ready", 32'(in_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_sum_kept", 32'(sum), 32'h10);
        chk("abort_cout_kept", 32'(cout), 0);
        ov_seen = 1'b0;
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            ov_seen = ov_seen | out_valid;
        end
        chk("abort_no_valid", 32'(ov_seen), 0);
        start_op(8'h10, 8'h20, 1'b0);
        wait_done(lat);
        chk("post_abort_latency", 32'(lat), W);
        chk("post_abort_sum", 32'(sum), 32'h30);
        @(posedge clk);
        #1;

        // Asynchronous reset between clock edges mid-RUN.
        start_op(8'hC3, 8'h3C, 1'b1);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_sum", 32'(sum), 0);
        chk("arst_cout", 32'(cout), 0);
        chk("arst_ready", 32'(in_ready), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_op(8'h01, 8'h02, 1'b1);
        wait_done(lat);
        chk("arst_op_latency", 32'(lat), W);
        chk("arst_op_sum_fa", 32'(sum), 32'h04);
        chk("arst_op_sum_ha", 32'(sum_h), 32'h03);
        @(posedge clk);
        #1;

        // Streaming with both handshakes held high.
        pops_before = n_pop;
        acc_n       = 0;
        last_cyc    = 0;
        a           = 8'h20;
        b           = 8'h40;
        cin         = 1'b1;
        in_valid    = 1'b1;
        for (int k = 0; k < 200 && acc_n < 6; k++) begin
            @(negedge clk);
            fire = in_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                if (acc_n > 0) chk("stream_period", 32'(cyc - last_cyc), W + 2);
                last_cyc = cyc;
                acc_n++;
                a = a + 8'h11;
                b = b + 8'h07;
            end
        end
        in_valid = 1'b0;
        chk("stream_accepts", 32'(acc_n), 6);
        for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clk);
        #1;
        chk("stream_drain", 32'(sb.size()), 0);
        chk("stream_results", 32'(n_pop - pops_before), 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
